traffic_sensor_frontend: RTL and testbench

Input-side front end for the traffic light controller. It conditions the raw pedestrian pushbutton into a held crossing request and turns raw vehicle-detector pulses on each road into 3-bit queue-level estimates. It produces the controller's pedButton, mainTrafficIn and sideTrafficIn signals. It also consumes the controller's MG, SG and pedLight outputs, so that requests are cleared and queues drained as the controller serves them.

---
 rtl/traffic_sensor_frontend.sv | 141 ++++++++++++++
 tb/tb_traffic_sensor_frontend.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_sensor_frontend.sv
// ============================================================================
// traffic_sensor_frontend
//    Conditions the pedestrian button and vehicle detectors into controller inputs.
//    Revision: 1.0
// ============================================================================
`default_nettype none

module traffic_sensor_frontend #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int DRAIN_CYCLES    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       pedButtonRaw,
   input  logic       mainCarPulse,
   input  logic       sideCarPulse,
   input  logic       MG,
   input  logic       SG,
   input  logic       pedLight,
   output logic       pedButton,
   output logic [2:0] mainTrafficIn,
   output logic [2:0] sideTrafficIn,
   output logic       pedWaiting
);

   localparam logic [7:0] DB_LAST  = 8'(DEBOUNCE_CYCLES - 1);
   localparam logic [7:0] DRN_LAST = 8'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      SERVING = 2'd2
   } ped_state_t;

   logic       btn_s1_q, btn_s2_q;
   logic       dbBtn_q;
   logic [7:0] db_cnt_q;
   logic       w_db_flip;
   logic       w_pressEv;
   ped_state_t state_q, state_d;
   logic       pedButton_q, pedWaiting_q;

   // The debounced value flips on the cycle the counter would reach its limit.
   assign w_db_flip = (btn_s2_q != dbBtn_q) && (db_cnt_q == DB_LAST);
   assign w_pressEv = w_db_flip && !dbBtn_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         btn_s1_q <= 1'b0;
         btn_s2_q <= 1'b0;
         dbBtn_q  <= 1'b0;
         db_cnt_q <= 8'd0;
      end else begin
         btn_s1_q <= pedButtonRaw;
         btn_s2_q <= btn_s1_q;
         if (btn_s2_q == dbBtn_q) begin
            db_cnt_q <= 8'd0;
         end else if (w_db_flip) begin
            dbBtn_q  <= btn_s2_q;
            db_cnt_q <= 8'd0;
         end else begin
            db_cnt_q <= db_cnt_q + 8'd1;
         end
      end
   end

   // Walk light takes priority over a simultaneous press.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (pedLight)       state_d = SERVING;
            else if (w_pressEv) state_d = ARMED;
         end
         ARMED:   if (pedLight)  state_d = SERVING;
         SERVING: if (!pedLight) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         pedButton_q  <= 1'b0;
         pedWaiting_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pedButton_q  <= (state_d == ARMED);
         pedWaiting_q <= (state_d == ARMED);
      end
   end

   assign pedButton  = pedButton_q;
   assign pedWaiting = pedWaiting_q;

   logic [1:0] w_car_raw;
   logic [1:0] w_green;
   logic [5:0] w_lvl;

   assign w_car_raw = {sideCarPulse, mainCarPulse};
   assign w_green   = {SG, MG};

   // Index 0 is the main road, index 1 the side road.
   for (genvar r = 0; r < 2; r++) begin : g_road
      logic       car_s1_q, car_s2_q, car_s3_q;
      logic [7:0] tmr_q;
      logic [2:0] lvl_q;
      logic       w_arrEv, w_drnEv;

      assign w_arrEv = car_s2_q && !car_s3_q;
      assign w_drnEv = w_green[r] && (tmr_q == DRN_LAST);

      always_ff @(posedge clk) begin
         if (reset) begin
            car_s1_q <= 1'b0;
            car_s2_q <= 1'b0;
            car_s3_q <= 1'b0;
            tmr_q    <= 8'd0;
            lvl_q    <= 3'd0;
         end else begin
            car_s1_q <= w_car_raw[r];
            car_s2_q <= car_s1_q;
            car_s3_q <= car_s2_q;
            if (!w_green[r] || w_drnEv) tmr_q <= 8'd0;
            else                        tmr_q <= tmr_q + 8'd1;
            if (w_arrEv && !w_drnEv && lvl_q != 3'd7)
               lvl_q <= lvl_q + 3'd1;
            else if (w_drnEv && !w_arrEv && lvl_q != 3'd0)
               lvl_q <= lvl_q - 3'd1;
         end
      end

      assign w_lvl[r*3 +: 3] = lvl_q;
   end

   assign mainTrafficIn = w_lvl[2:0];
   assign sideTrafficIn = w_lvl[5:3];

endmodule

`default_nettype wire

// File: tb/tb_traffic_sensor_frontend.sv
// ============================================================================
// tb_traffic_sensor_frontend
//    Directed bench for the traffic sensor front end.
//    Revision: 1.0
// ============================================================================
`default_nettype none

module tb_traffic_sensor_frontend;

   logic       clk = 1'b0;
   logic       reset;
   logic       pedButtonRaw, mainCarPulse, sideCarPulse;
   logic       MG, SG, pedLight;
   logic       pedButton, pedWaiting;
   logic [2:0] mainTrafficIn, sideTrafficIn;

   int n_tests = 0;
   int n_fail  = 0;
   int ped_rises = 0;

   always #5 clk = ~clk;

   always @(posedge pedButton) ped_rises++;

   traffic_sensor_frontend #(
      .DEBOUNCE_CYCLES(4),
      .DRAIN_CYCLES   (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pedButtonRaw (pedButtonRaw),
      .mainCarPulse (mainCarPulse),
      .sideCarPulse (sideCarPulse),
      .MG           (MG),
      .SG           (SG),
      .pedLight     (pedLight),
      .pedButton    (pedButton),
      .mainTrafficIn(mainTrafficIn),
      .sideTrafficIn(sideTrafficIn),
      .pedWaiting   (pedWaiting)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_val(input string tag, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic main_car();
      mainCarPulse = 1'b1;
      ticks(2);
      mainCarPulse = 1'b0;
      ticks(2);
   endtask

   task automatic side_car();
      sideCarPulse = 1'b1;
      ticks(2);
      sideCarPulse = 1'b0;
      ticks(2);
   endtask

   // Side road green from cycle 0; pulse rises after cycle 5 so arrival lands on the first drain edge.
   task automatic side_coincide(input int lvl, input string tag);
      SG = 1'b1;
      for (int k = 1; k <= 9; k++) begin
         tick();
         if (k == 5) sideCarPulse = 1'b1;
         if (k == 8) begin
            sideCarPulse = 1'b0;
            check_val({tag, "_at_drain"}, sideTrafficIn, lvl);
         end
         if (k == 9) check_val({tag, "_after"}, sideTrafficIn, lvl);
      end
      SG = 1'b0;
      ticks(3);
   endtask

   int base_rises;

   initial begin
      reset = 1'b1;
      pedButtonRaw = 1'b0; mainCarPulse = 1'b0; sideCarPulse = 1'b0;
      MG = 1'b0; SG = 1'b0; pedLight = 1'b0;
      ticks(2);
      reset = 1'b0;
      tick();
      check_val("rst_pedButton",  pedButton,     0);
      check_val("rst_pedWaiting", pedWaiting,    0);
      check_val("rst_main",       mainTrafficIn, 0);
      check_val("rst_side",       sideTrafficIn, 0);

      // Bouncy press: 1,0,1 then hold; steady high starts after edge 2.
      base_rises = ped_rises;
      pedButtonRaw = 1'b1;
      tick();
      pedButtonRaw = 1'b0;
      tick();
      pedButtonRaw = 1'b1;
      ticks(5);
      check_val("bounce_early", pedButton, 0);
      tick();
      check_val("bounce_press",   pedButton,  1);
      check_val("bounce_waiting", pedWaiting, 1);
      ticks(4);
      check_val("bounce_one_rise", ped_rises - base_rises, 1);

      pedButtonRaw = 1'b0;
      ticks(8);
      check_val("armed_hold", pedButton, 1);

      // Walk for 10 cycles with a press during walk.
      pedLight = 1'b1;
      tick();
      check_val("walk_clear",   pedButton,  0);
      check_val("walk_waiting", pedWaiting, 0);
      pedButtonRaw = 1'b1;
      ticks(9);
      pedButtonRaw = 1'b0;
      pedLight = 1'b0;
      ticks(9);
      check_val("walk_press_dropped", pedButton, 0);

      pedButtonRaw = 1'b1;
      ticks(5);
      check_val("rearm_early", pedButton, 0);
      tick();
      check_val("rearm_press", pedButton, 1);
      pedButtonRaw = 1'b0;
      ticks(8);

      // Mid-operation reset with queue 5 and a pending request.
      for (int i = 0; i < 5; i++) main_car();
      check_val("pre_rst_main", mainTrafficIn, 5);
      check_val("pre_rst_ped",  pedButton,     1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check_val("midrst_main", mainTrafficIn, 0);
      check_val("midrst_ped",  pedButton,     0);
      tick();
      check_val("midrst_wait", pedWaiting, 0);

      // Arrival latency, then saturation at 7.
      mainCarPulse = 1'b1;
      ticks(2);
      check_val("arr_lat_early", mainTrafficIn, 0);
      mainCarPulse = 1'b0;
      tick();
      check_val("arr_lat", mainTrafficIn, 1);
      tick();
      for (int i = 2; i <= 9; i++) begin
         main_car();
         check_val($sformatf("arr_%0d", i), mainTrafficIn, (i > 7) ? 7 : i);
      end
      check_val("arr_side_idle", sideTrafficIn, 0);

      // Drain from 3 with continuous green.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) main_car();
      check_val("drn_start", mainTrafficIn, 3);
      MG = 1'b1;
      for (int k = 1; k <= 24; k++) begin
         tick();
         if (k == 7)  check_val("drn_7",  mainTrafficIn, 3);
         if (k == 8)  check_val("drn_8",  mainTrafficIn, 2);
         if (k == 15) check_val("drn_15", mainTrafficIn, 2);
         if (k == 16) check_val("drn_16", mainTrafficIn, 1);
         if (k == 24) check_val("drn_24", mainTrafficIn, 0);
      end
      MG = 1'b0;
      tick();

      // Green dropout at cycle 12 restarts the timer.
      for (int i = 0; i < 3; i++) main_car();
      MG = 1'b1;
      for (int k = 1; k <= 21; k++) begin
         tick();
         if (k == 8)  check_val("rst_tmr_8", mainTrafficIn, 2);
         if (k == 12) MG = 1'b0;
         if (k == 13) MG = 1'b1;
         if (k == 17) check_val("rst_tmr_17", mainTrafficIn, 2);
         if (k == 20) check_val("rst_tmr_20", mainTrafficIn, 2);
         if (k == 21) check_val("rst_tmr_21", mainTrafficIn, 1);
      end
      MG = 1'b0;
      tick();

      // Arrival coinciding with drain at both queue limits.
      side_coincide(0, "coin_q0");
      for (int i = 0; i < 7; i++) side_car();
      check_val("side_fill", sideTrafficIn, 7);
      side_coincide(7, "coin_q7");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
